// File: rtl/store_bus_adapter_pkg.sv
// Shared store-unit types and pure lane helpers, reused by the load side.
package store_bus_adapter_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } store_width_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ISSUE    = 2'b01,
        ST_WAIT_ACK = 2'b10,
        ST_DONE     = 2'b11
    } adapter_state_t;

    function automatic logic [3:0] strobe_gen(input logic [1:0] width, input logic [1:0] addr_lo);
        logic [3:0] strobe;
        case (width)
            BYTE:    strobe = 4'b0001 << addr_lo;
            HALF:    strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
            WORD:    strobe = 4'b1111;
            default: strobe = 4'b0000;
        endcase
        return strobe;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [1:0] width, input logic [31:0] data);
        logic [31:0] lanes;
        case (width)
            BYTE:    lanes = {4{data[7:0]}};
            HALF:    lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    // Reserved encoding 2'b11 is rejected like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic mis;
        case (width)
            BYTE:    mis = 1'b0;
            HALF:    mis = addr_lo[0];
            WORD:    mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_bus_adapter_checker.sv
// Protocol checker: the store buffer must only present an entry while the adapter is idle.
module store_bus_adapter_checker (
    input logic clk_i,
    input logic rst_n_i,
    input logic store_request_i,
    input logic idle
);

    request_only_when_idle: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        store_request_i |-> idle);

endmodule

// File: rtl/store_bus_adapter_lane_aligner.sv
// Combinational byte-lane alignment: replicated data, strobe and misalignment flag.
module store_lane_aligner
    import store_bus_adapter_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    input  logic [1:0]  width,
    output logic [31:0] lane_data,
    output logic [3:0]  strobe,
    output logic        misaligned
);

    assign lane_data  = lane_replicate(width, data);
    assign strobe     = strobe_gen(width, addr_lo);
    assign misaligned = is_misaligned(width, addr_lo);

endmodule

// File: rtl/store_bus_adapter.sv
// Converts one committed store into a strobed bus write with bounded retry and ack timeout.
module store_bus_adapter
    import store_bus_adapter_pkg::*;
#(
    parameter int MAX_RETRY      = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        store_request_i,
    input  logic [31:0] store_address_i,
    input  logic [31:0] store_data_i,
    input  logic [1:0]  store_width_i,
    output logic        store_done_o,
    output logic        misaligned_o,
    output logic        bus_error_o,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic [31:0] bus_address_o,
    output logic [31:0] bus_data_o,
    output logic [3:0]  bus_strobe_o,
    input  logic        bus_ack_i,
    input  logic        bus_error_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_SAT  = {TW{1'b1}};
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    adapter_state_t state_r;
    logic [TW-1:0]  tmo_cnt_r;
    logic [RW-1:0]  retry_cnt_r;
    logic [31:0]    addr_r;
    logic [31:0]    data_r;
    logic [3:0]     strobe_r;
    logic           valid_r;
    logic           done_r;
    logic           misaligned_r;
    logic           bus_error_r;

    logic [31:0]    lane_data_s;
    logic [3:0]     strobe_s;
    logic           misaligned_s;
    logic           attempt_failed_s;

    store_lane_aligner u_aligner (
        .addr_lo    (store_address_i[1:0]),
        .data       (store_data_i),
        .width      (store_width_i),
        .lane_data  (lane_data_s),
        .strobe     (strobe_s),
        .misaligned (misaligned_s)
    );

    store_bus_adapter_checker u_checker (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .store_request_i (store_request_i),
        .idle            (state_r == ST_IDLE)
    );

    // Error takes priority over a simultaneous ack; silence past the window also fails the attempt.
    always_comb begin
        attempt_failed_s = 1'b0;
        if (bus_error_i) begin
            attempt_failed_s = 1'b1;
        end else if (!bus_ack_i && (tmo_cnt_r == TMO_LAST)) begin
            attempt_failed_s = 1'b1;
        end else begin
            attempt_failed_s = 1'b0;
        end
    end

    // Adapter FSM with registered bus and completion outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= ST_IDLE;
            tmo_cnt_r    <= '0;
            retry_cnt_r  <= '0;
            addr_r       <= 32'h0000_0000;
            data_r       <= 32'h0000_0000;
            strobe_r     <= 4'b0000;
            valid_r      <= 1'b0;
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            bus_error_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (store_request_i) begin
                        addr_r   <= {store_address_i[31:2], 2'b00};
                        data_r   <= lane_data_s;
                        strobe_r <= strobe_s;
                        if (misaligned_s) begin
                            state_r      <= ST_DONE;
                            done_r       <= 1'b1;
                            misaligned_r <= 1'b1;
                        end else begin
                            state_r <= ST_ISSUE;
                            valid_r <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus_ready_i) begin
                        state_r   <= ST_WAIT_ACK;
                        valid_r   <= 1'b0;
                        tmo_cnt_r <= '0;
                    end
                end
                ST_WAIT_ACK: begin
                    if (tmo_cnt_r != TMO_SAT) begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                    if (attempt_failed_s) begin
                        if (retry_cnt_r < RETRY_LIMIT) begin
                            retry_cnt_r <= retry_cnt_r + 1'b1;
                            state_r     <= ST_ISSUE;
                            valid_r     <= 1'b1;
                        end else begin
                            state_r     <= ST_DONE;
                            done_r      <= 1'b1;
                            bus_error_r <= 1'b1;
                        end
                    end else if (bus_ack_i) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    done_r       <= 1'b0;
                    misaligned_r <= 1'b0;
                    bus_error_r  <= 1'b0;
                    retry_cnt_r  <= '0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign store_done_o  = done_r;
    assign misaligned_o  = misaligned_r;
    assign bus_error_o   = bus_error_r;
    assign bus_valid_o   = valid_r;
    assign bus_address_o = addr_r;
    assign bus_data_o    = data_r;
    assign bus_strobe_o  = strobe_r;

endmodule

// File: doc/store_bus_adapter.md
Name: store_bus_adapter

Overview:
Downstream consumer of the store buffer pull channel. It latches one committed store (address, data, width) and converts it into a byte-lane-aligned, strobed bus write. It then runs the bus valid/ready + ack handshake, with bounded retry on error and an ack timeout. It returns a single-cycle done pulse so the store buffer can advance its pull pointer.

Parameters:
MAX_RETRY, 2, number of re-issues after a bus error or timeout before the store is reported failed (0 = no retry)
TIMEOUT_CYCLES, 64, cycles spent in WAIT_ACK without ack or error before the attempt counts as failed

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
store_request_i  in  1  one-cycle pulse: store entry presented
store_address_i  in  32  byte address of store
store_data_i  in  32  store data, LSB-justified
store_width_i  in  2  store_width_t (BYTE/HALF/WORD)
store_done_o  out  1  one-cycle pulse: entry retired (success or failure)
misaligned_o  out  1  pulse with store_done_o: entry rejected as misaligned
bus_error_o  out  1  pulse with store_done_o: retries exhausted
bus_valid_o  out  1  write request valid
bus_ready_i  in  1  bus accepts request when valid & ready
bus_address_o  out  32  word-aligned address ({addr[31:2],2'b00})
bus_data_o  out  32  lane-replicated data
bus_strobe_o  out  4  byte enables
bus_ack_i  in  1  write completed
bus_error_i  in  1  write failed (same cycle slot as ack; error wins if both asserted)

Behaviour:
- Reset (async, any state): FSM=IDLE; retry/timeout counters 0; all outputs 0; holding registers 0. An in-flight bus transaction is abandoned and no done is issued.
- FSM states:
  - IDLE, ISSUE, WAIT_ACK, DONE.
  - IDLE: store_request_i latches address/data/width and checks alignment.
  - IDLE -> DONE if misaligned: misaligned_o is set; no bus activity.
  - IDLE -> ISSUE otherwise.
  - A request arriving outside IDLE is a protocol violation: ignored, flagged by an assertion.
- Alignment rules:
  - BYTE: always aligned.
  - HALF: requires addr[0]=0.
  - WORD: requires addr[1:0]=00.
  - Width encoding 2'b11 is treated as misaligned.
- Lane generation (registered at latch, stable through the transaction):
  - BYTE: data = {4{d[7:0]}}, strobe = 4'b0001 << addr[1:0].
  - HALF: data = {2{d[15:0]}}, strobe = addr[1] ? 4'b1100 : 4'b0011.
  - WORD: data = d, strobe = 4'b1111.
- ISSUE: bus_valid_o=1. Address, data and strobe are held constant until bus_ready_i. On valid & ready -> WAIT_ACK, clear the timeout counter.
- WAIT_ACK: bus_valid_o=0; the timeout counter increments each cycle.
  - bus_ack_i (no error) -> DONE, success.
  - bus_error_i, or counter reaching TIMEOUT_CYCLES-1 without ack: if retry count < MAX_RETRY, increment it and go to ISSUE (re-issue the identical write). Otherwise go to DONE with bus_error_o.
- DONE: store_done_o=1 for exactly one cycle, together with misaligned_o/bus_error_o as applicable. Then -> IDLE and clear the retry counter.
- Latency:
  - Best case: request at c0, valid at c1 with ready, ack at c2, done at c3.
  - Misaligned: done at c1.
  - The next request is accepted no earlier than the cycle after done.
- Counters:
  - Timeout counter width $clog2(TIMEOUT_CYCLES+1), saturating.
  - Retry counter width $clog2(MAX_RETRY+1), minimum 1 bit.
- bus_ack_i/bus_error_i outside WAIT_ACK are ignored.

Decomposition:
- Shared store-unit package holds:
  - store_width_t enum (BYTE=2'b00, HALF=2'b01, WORD=2'b10).
  - adapter FSM state enum.
  - a pure function for strobe generation and one for lane replication, so the load side can reuse them.
- Natural sub-module: store_lane_aligner (combinational address/width/data -> aligned data, strobe, misaligned flag), instantiated once before the holding registers.

Test Plan:
- WORD store, addr 0x0000_1004, data 0xDEADBEEF, ready=1, ack 1 cycle later:
  - bus_address_o=0x0000_1004, strobe=1111, data=0xDEADBEEF.
  - done pulses at c3; no error flags.
- BYTE store, addr 0x103, data 0x000000A5:
  - bus_data_o=0xA5A5A5A5, strobe=1000, bus_address_o=0x100.
- HALF addr 0x102 data 0x1234: strobe=1100, data=0x12341234.
- HALF addr 0x101: no bus_valid_o; done and misaligned_o both at c1.
- MAX_RETRY=2, bus_error_i on every attempt:
  - exactly 3 valid&ready handshakes, identical payload each time.
  - done with bus_error_o after the third error.
- Timeout and reset:
  - TIMEOUT_CYCLES=8 with ack never asserted: re-issue after 8 WAIT_ACK cycles.
  - Assert rst_n_i low mid-WAIT_ACK: all outputs 0 immediately; no done after release.
